// File: rtl/uart_pkg.sv
// Shared types and default addresses for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam logic [31:0] UART_TX_ADDR  = 32'h0000_00F0;
  localparam logic [31:0] UART_CLR_ADDR = UART_TX_ADDR + 32'd4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a head-of-queue read port and an occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Fullness and emptiness come from the registered count, so a same-edge
  // pop never makes room for a push into a full queue.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-snooping UART transmitter: queues byte stores to TX_ADDR and sends
// them as 8N1 frames on tx; stores to TX_ADDR+4 clear the overflow flag.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = UART_TX_ADDR,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          MemWrite,
  input  logic [31:0]                   DataAdr,
  input  logic [31:0]                   WriteData,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned    CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]    CLR_ADDR = TX_ADDR + 32'd4;

  uart_state_t      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_d;
  logic [7:0]       shift, shift_d;
  logic             tx_d, busy_d, overflow_d;

  logic             tx_hit, clr_hit;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic             unused_data;

  assign tx_hit      = MemWrite && (DataAdr == TX_ADDR);
  assign clr_hit     = MemWrite && (DataAdr == CLR_ADDR);
  assign unused_data = ^WriteData[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_hit),
    .pop   (fifo_pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic; tx/tx_busy are derived from the next state so the
  // registered line reflects the state being entered on this edge.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    bit_d      = bit_idx;
    shift_d    = shift;
    fifo_pop   = 1'b0;
    overflow_d = overflow;

    if (tx_hit && fifo_full) overflow_d = 1'b1;
    else if (clr_hit)        overflow_d = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_d = STOP;
          else                 bit_d   = bit_idx + 3'd1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      shift    <= shift_d;
      tx       <= tx_d;
      tx_busy  <= busy_d;
      overflow <= overflow_d;
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle ARM core's data-memory bus, beside data memory in `top`. It snoops the core's store interface (`MemWrite`, `DataAdr`, `WriteData`) and captures byte stores to its TX address into a small FIFO. It serialises queued bytes as 8N1 frames on `tx`, giving test programs a visible character output channel.

## Interface
Parameters:
- `TX_ADDR`, 32'h0000_00F0: word address whose stores enqueue a byte.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit. Must be ≥1.
- `FIFO_DEPTH`, 4: byte entries. Must be a power of two, ≥2.

Ports:
- `clk` input 1: sole clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low reset. Sampled on the `clk` rising edge; 0 = reset.
- `MemWrite` input 1: core store strobe.
- `DataAdr` input 32: core data address.
- `WriteData` input 32: core store data. Only `[7:0]` is used.
- `tx` output 1: serial line, idle high.
- `tx_busy` output 1: high while a frame is on the line (FSM not IDLE).
- `fifo_count` output $clog2(FIFO_DEPTH)+1: queued bytes, not including the byte in flight.
- `overflow` output 1: sticky flag set when a store is dropped.

## Operation
- **Push:** on an edge with `MemWrite`=1 and `DataAdr`==`TX_ADDR`:
  - if registered `fifo_count` < `FIFO_DEPTH`, push `WriteData[7:0]`;
  - otherwise drop the byte and set `overflow`.
  - Fullness is judged on the pre-edge count, so a pop on the same edge does not rescue a write to a full FIFO.
- **Clear:** a store to `TX_ADDR`+4 clears `overflow`. Its data is ignored. Any other address is ignored.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA with bit index 0.
  - DATA: `tx`=`shift[0]` (LSB first) for `CLKS_PER_BIT` cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At its last cycle:
    - FIFO non-empty: pop and go directly to START (no idle gap);
    - FIFO empty: go to IDLE.
- **Counters:** the bit-period counter counts 0..`CLKS_PER_BIT`-1 and wraps. The bit index is 3 bits. The FIFO pointers wrap modulo `FIFO_DEPTH`.
- **Simultaneous push and pop:** both take effect; `fifo_count` is unchanged.

## Timing
- **Reset values** (one edge with `reset`=0):
  - `tx`=1, `tx_busy`=0, `fifo_count`=0, `overflow`=0, FSM=IDLE;
  - pointers and counters 0.
  - The FIFO contents are discarded.
- **Reset mid-frame:** the frame is aborted and `tx` is 1 after that edge.
- **Registered outputs:** `tx` and `tx_busy` are registered; there is no combinational input-to-output path.
- **Latency**, for a store at edge E into an empty FIFO while IDLE:
  - `fifo_count`=1 after E;
  - at E+1 the byte is popped: `fifo_count`=0, `tx_busy`=1, `tx`=0.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles of `tx_busy`=1 per byte.
- **Back-to-back frames:** `tx_busy` stays high across them.
- **Overflow:** `overflow` is set after the dropping edge and holds until cleared or reset. Clear and drop on the same edge cannot occur, because the addresses differ.

## Structure
- **Package `uart_pkg`:**
  - state enum `uart_state_t` {IDLE, START, DATA, STOP};
  - default constants `UART_TX_ADDR` and `UART_CLR_ADDR` (`TX_ADDR`+4).
- **Sub-module `sync_fifo`:** parameterised width/depth, with the same clock and reset convention. Ports:
  - `push`, `pop`, `din`, `dout`, `count`, `full`, `empty`.
- **Top-level module:** `mmio_uart_tx` contains the address decode, overflow flag, FSM and shift/period counters.
- **Integration:** instantiated in `top` alongside data memory. The testbench decodes `tx` or watches `DataAdr`.

## Test plan
Defaults: `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.

- **Single byte.** Store 32'h0000_0055 to 0xF0 at edge E.
  - `tx` low for 4 cycles from E+1.
  - Then bits 1,0,1,0,1,0,1,0, 4 cycles each.
  - Then high for 4 cycles.
  - `tx_busy` is high for 40 cycles.
- **Byte lane and decode.**
  - Store 32'hDEAD_BEA5 to 0xF0: the frame carries 0xA5.
  - Stores to 0xEC and 0xF8: no change.
  - Loads (`MemWrite`=0) to 0xF0: no change.
- **Overflow.** Six back-to-back stores 0x41..0x46.
  - 0x41 is popped at edge 2.
  - 0x42..0x45 are queued (`fifo_count`=4).
  - 0x46 is dropped and `overflow`=1.
  - Exactly 0x41..0x45 are transmitted consecutively, with no idle gap.
- **Clear.** Store any value to 0xF4: `overflow`=0 next cycle. A later store to 0xF0 transmits normally.
- **Reset mid-frame.** Assert `reset`=0 for one edge during DATA with 2 bytes queued.
  - After that edge: `tx`=1, `tx_busy`=0, `fifo_count`=0.
  - No further frames follow.
- **Push and pop on the same edge.** A store lands on the STOP-final edge with one byte queued: `fifo_count` stays 1 and the next frame starts immediately.
